shift_add_mult_ctrl: RTL and testbench
======================================

Name: shift_add_mult_ctrl

Overview:
- Control FSM for the 32-bit shift-and-add multiplier datapath; sits directly upstream of it.
- Drives every datapath select (a_sel, b_sel, add_sel, prod_sel) and Shift_Enable, and consumes the datapath's B LSB.
- Gives the system a Start/Busy/Done handshake. Prod is valid in the datapath from the cycle Done pulses until the next Start is accepted.

Parameters:
- WIDTH, 32, operand width; equals the number of ITERATE cycles per multiply.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- Clock  input  1  system clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  request a multiply; sampled only in IDLE.
- B_LSB  input  1  bit 0 of the datapath B register.
- a_sel  output  1  1 = load A operand, 0 = feed back shifted A.
- b_sel  output  1  1 = load B operand, 0 = feed back shifted B.
- prod_sel  output  1  1 = clear product to 0, 0 = take add/hold path.
- add_sel  output  1  0 = accumulate (product + A), 1 = hold product.
- Shift_Enable  output  1  high while iterating.
- Busy  output  1  high in LOAD and ITERATE.
- Done  output  1  one-cycle pulse when Prod is final.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE, counter=0. Outputs in the IDLE pattern: a_sel=1, b_sel=1, prod_sel=0, add_sel=1, Shift_Enable=0, Busy=0, Done=0.
- Reset release is synchronised by the Clock edge; the first transition occurs no earlier than the second posedge after deassertion.
- States: IDLE, LOAD, ITERATE, DONE.
- IDLE:
  - Datapath A/B track the inputs; product is held.
  - Start=1 at a posedge -> LOAD.
- LOAD (1 cycle):
  - a_sel=1, b_sel=1, prod_sel=1 (product cleared), add_sel=1, Busy=1, counter cleared to 0.
  - Always -> ITERATE.
- ITERATE:
  - a_sel=0, b_sel=0, prod_sel=0, Shift_Enable=1, Busy=1.
  - add_sel = ~B_LSB. This is combinational (Mealy) from B_LSB and is the only non-registered decode.
  - Counter increments each cycle. When counter==WIDTH-1 -> DONE, so exactly WIDTH ITERATE cycles are produced.
- DONE (1 cycle):
  - Done=1, Busy=0; selects in the IDLE pattern, so product is held.
  - Always -> IDLE.
- Latency: Start sampled at edge t gives LOAD in cycle t+1, ITERATE in cycles t+2..t+WIDTH+1, and DONE at t+WIDTH+2 (WIDTH=32: Done 34 cycles after Start).
- Start while Busy or in DONE is ignored; no queuing.
- Start held high continuously: DONE -> IDLE -> LOAD. There is one IDLE cycle between operations, and Done pulses once per operation.
- B_LSB is ignored outside ITERATE.
- Counter uses no wrap-around: it saturates logic-wise because DONE exits at WIDTH-1, and it is reloaded in LOAD.
- Reset asserted mid-operation: immediate return to IDLE outputs; Done is not pulsed; the datapath product is undefined until the next completed multiply.
- Every output other than add_sel is a pure function of the registered state, so it is glitch-free.

Decomposition:
- Shared package holds:
  - State encoding constants: ST_IDLE=0, ST_LOAD=1, ST_ITERATE=2, ST_DONE=3 (2-bit).
  - Select encodings SEL_LOAD=1 and SEL_FEEDBACK=0 (a/b/prod muxes).
  - ADD_ACC=0 and ADD_HOLD=1.
- One sub-module, iter_counter (CNT_W bits, with clear, increment and terminal-count compare against WIDTH-1). The FSM and output decode stay in the top.

Test Plan:
- Reset low mid-ITERATE (cycle 10 after Start) -> next sample shows IDLE pattern, Busy=0; Done never pulses; a following Start with 5x3 yields Prod=15.
- Start=1 one cycle, A=7, B=6, controller wired to the datapath -> Busy high 33 cycles, Done pulses at cycle 34, Prod=42 (0x2A).
- A=0xFFFFFFFF, B=0xFFFFFFFF -> Done at cycle 34, Prod=0x FFFFFFFE00000001.
- B=0x0000000A with B_LSB driven by a model -> add_sel sequence over ITERATE cycles 1..4 is 1,0,1,0, then 1 for the remaining 28 cycles; Shift_Enable=1 for exactly 32 cycles.
- Start pulsed again at cycles 5 and 20 of an operation -> ignored; exactly one Done at cycle 34; second Start after Done -> new LOAD one cycle later.
- Start held high for 100 cycles, A=3, B=4 -> Done pulses at cycles 34 and 69 (one IDLE gap); Prod=12 at each Done.

Source files
------------

// File: rtl/shift_add_mult_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// shift_add_mult_ctrl_pkg : shared state and select encodings for the
//                           shift-and-add multiplier controller.  Rev 1.0
// ============================================================================
package shift_add_mult_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_ITERATE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // a/b/prod mux selects
  localparam logic SEL_LOAD     = 1'b1;
  localparam logic SEL_FEEDBACK = 1'b0;

  // add/hold select for the product register
  localparam logic ADD_ACC  = 1'b0;
  localparam logic ADD_HOLD = 1'b1;

endpackage : shift_add_mult_ctrl_pkg
`default_nettype wire

// File: rtl/shift_add_mult_ctrl_iter_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// iter_counter : iteration counter with clear, increment and terminal-count
//                flag at WIDTH-1.  Rev 1.0
// ============================================================================
module iter_counter
  import shift_add_mult_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] count;

  // Holds at WIDTH-1 rather than wrapping; LOAD reloads it for the next run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !last) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == LAST_VAL);

endmodule : iter_counter
`default_nettype wire

// File: rtl/shift_add_mult_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// shift_add_mult_ctrl : control FSM for the shift-and-add multiplier datapath
//                       with Start/Busy/Done handshake.  Rev 1.0
// ============================================================================
module shift_add_mult_ctrl
  import shift_add_mult_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Start,
  input  logic B_LSB,
  output logic a_sel,
  output logic b_sel,
  output logic prod_sel,
  output logic add_sel,
  output logic Shift_Enable,
  output logic Busy,
  output logic Done
);

  logic [1:0] rst_sync;
  logic       rst_n;
  state_t     state;
  state_t     state_next;
  logic       cnt_clr;
  logic       cnt_inc;
  logic       cnt_last;

  // Assert asynchronously, release on the second clock edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign cnt_clr = (state == ST_LOAD);
  assign cnt_inc = (state == ST_ITERATE);

  iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk   (Clock),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .last  (cnt_last)
  );

  always_comb begin
    state_next   = state;
    a_sel        = SEL_LOAD;
    b_sel        = SEL_LOAD;
    prod_sel     = SEL_FEEDBACK;
    add_sel      = ADD_HOLD;
    Shift_Enable = 1'b0;
    Busy         = 1'b0;
    Done         = 1'b0;

    case (state)
      ST_IDLE: begin
        if (Start) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        prod_sel   = SEL_LOAD;
        Busy       = 1'b1;
        state_next = ST_ITERATE;
      end
      ST_ITERATE: begin
        a_sel        = SEL_FEEDBACK;
        b_sel        = SEL_FEEDBACK;
        // Only Mealy decode: accumulate when the current multiplier bit is 1.
        add_sel      = B_LSB ? ADD_ACC : ADD_HOLD;
        Shift_Enable = 1'b1;
        Busy         = 1'b1;
        if (cnt_last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        Done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule : shift_add_mult_ctrl
`default_nettype wire

// File: tb/tb_shift_add_mult_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_shift_add_mult_ctrl : controller driving a behavioural datapath, checked
//                          against cycle/phase expectations and A*B.  Rev 1.0
// ============================================================================
module tb_shift_add_mult_ctrl;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic Start = 1'b0;
  logic B_LSB;
  logic a_sel, b_sel, prod_sel, add_sel, Shift_Enable, Busy, Done;

  logic [31:0] a_in  = '0;
  logic [31:0] b_in  = '0;
  logic [63:0] a_reg = '0;
  logic [31:0] b_reg = '0;
  logic [63:0] prod  = '0;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] PAT_IDLE = 7'b1101000;
  localparam logic [6:0] PAT_LOAD = 7'b1111010;
  localparam logic [6:0] PAT_DONE = 7'b1101001;

  shift_add_mult_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Start        (Start),
    .B_LSB        (B_LSB),
    .a_sel        (a_sel),
    .b_sel        (b_sel),
    .prod_sel     (prod_sel),
    .add_sel      (add_sel),
    .Shift_Enable (Shift_Enable),
    .Busy         (Busy),
    .Done         (Done)
  );

  always #5 Clock = ~Clock;

  // Datapath the controller steers: A shifts left, B shifts right.
  always @(posedge Clock) begin
    a_reg <= a_sel ? {32'd0, a_in} : (Shift_Enable ? (a_reg << 1) : a_reg);
    b_reg <= b_sel ? b_in : (Shift_Enable ? (b_reg >> 1) : b_reg);
    prod  <= prod_sel ? 64'd0 : (add_sel ? prod : prod + a_reg);
  end

  assign B_LSB = b_reg[0];

  wire [6:0] outs = {a_sel, b_sel, prod_sel, add_sel, Shift_Enable, Busy, Done};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs in cycle k after the Start-sampling edge.
  function automatic logic [6:0] exp_outs(input int k, input logic [31:0] b);
    if (k == 1)             return PAT_LOAD;
    if (k >= 2 && k <= 33)  return {3'b000, ~b[k-2], 3'b110};
    if (k == 34)            return PAT_DONE;
    return PAT_IDLE;
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit extra_starts);
    logic [63:0] expect_prod;
    expect_prod = {32'd0, a} * {32'd0, b};
    @(negedge Clock);
    a_in  = a;
    b_in  = b;
    Start = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      @(negedge Clock);
      Start = extra_starts && (k == 5 || k == 20);
      chk($sformatf("outs_c%0d", k), {57'd0, outs}, {57'd0, exp_outs(k, b)});
      if (k == 34) chk("prod", prod, expect_prod);
    end
    Start = 1'b0;
  endtask

  initial begin
    int dones;
    int waited;
    bit seen;

    // Reset state
    #1;
    chk("reset_outs", {57'd0, outs}, {57'd0, PAT_IDLE});
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    repeat (3) begin
      @(negedge Clock);
      chk("idle_after_reset", {57'd0, outs}, {57'd0, PAT_IDLE});
    end

    do_op(32'd7, 32'd6, 1'b0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op($urandom, 32'h0000_000A, 1'b0);
    do_op($urandom, $urandom, 1'b1);
    do_op($urandom, $urandom, 1'b0);
    do_op(32'd0, $urandom, 1'b0);
    repeat (4) do_op($urandom, $urandom, 1'b0);

    // Reset mid-ITERATE, cycle 10 after Start
    @(negedge Clock);
    a_in  = $urandom;
    b_in  = $urandom;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (9) @(negedge Clock);
    chk("pre_reset_busy", {63'd0, Busy}, 64'd1);
    #2 Reset = 1'b0;
    #1 chk("mid_reset_outs", {57'd0, outs}, {57'd0, PAT_IDLE});
    @(negedge Clock);
    chk("reset_held_outs", {57'd0, outs}, {57'd0, PAT_IDLE});
    Reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clock);
      chk("post_reset_quiet", {57'd0, outs}, {57'd0, PAT_IDLE});
    end
    do_op(32'd5, 32'd3, 1'b0);

    // Start held high: Done at 34 and 69
    @(negedge Clock);
    a_in  = 32'd3;
    b_in  = 32'd4;
    Start = 1'b1;
    dones = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge Clock);
      if (Done) begin
        dones++;
        chk($sformatf("held_done%0d_cycle", dones), 64'(k), (dones == 1) ? 64'd34 : 64'd69);
        chk("held_prod", prod, 64'd12);
      end
    end
    chk("held_done_count", 64'(dones), 64'd2);
    Start  = 1'b0;
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < 40) begin
      @(negedge Clock);
      waited++;
      seen = Done;
    end
    chk("held_drain_done", {63'd0, seen}, 64'd1);
    chk("held_drain_prod", prod, 64'd12);
    @(negedge Clock);
    chk("final_idle", {57'd0, outs}, {57'd0, PAT_IDLE});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_shift_add_mult_ctrl
`default_nettype wire
